// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the convolution window address generator.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    // Number of valid window positions along one axis (floor division).
    function automatic int ofm_dim(input int ifm, input int k, input int stride);
        return (ifm - k) / stride + 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/conv_axis_counter.sv
// Wrapping loop counter for one window axis: counts 0..MAX on en, clr forces zero.
module conv_axis_counter #(
    parameter int MAX   = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == WIDTH'(MAX));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every KxK window of an IFM_W x IFM_H feature map and emits pixel read addresses
// under valid/ready, one beat per cycle while ready is high, holding steady on stall.
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int IFM_W  = 14,
    parameter int IFM_H  = 14,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    input  logic              addr_ready_i,
    output logic              win_first_o,
    output logic              win_last_o
);

    localparam int OFM_W = ofm_dim(IFM_W, K, STRIDE);
    localparam int OFM_H = ofm_dim(IFM_H, K, STRIDE);
    localparam int KW    = cnt_width(K - 1);
    localparam int OWW   = cnt_width(OFM_W - 1);
    localparam int OHW   = cnt_width(OFM_H - 1);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IFM_W);
    localparam logic [ADDR_W-1:0] ROW_KBACK = ADDR_W'((K - 1) * IFM_W);
    localparam logic [ADDR_W-1:0] ROW_OSTEP = ADDR_W'(STRIDE * IFM_W);
    localparam logic [ADDR_W-1:0] COL_KBACK = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] COL_OSTEP = ADDR_W'(STRIDE);

    conv_state_t       state_q, state_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;

    logic [KW-1:0]  kx_cnt, ky_cnt;
    logic [OWW-1:0] ox_cnt;
    logic [OHW-1:0] oy_cnt;
    logic           kx_wrap, ky_wrap, ox_wrap, oy_wrap;
    logic           fire, clr, last_beat;

    assign fire      = valid_q && addr_ready_i;
    assign clr       = (state_q == ST_IDLE) && start_i;
    assign last_beat = kx_wrap && ky_wrap && ox_wrap && oy_wrap;

    conv_axis_counter #(.MAX(K - 1), .WIDTH(KW)) u_kx (
        .clk(clk), .rst_n(rst_n), .en(fire), .clr(clr), .cnt_o(kx_cnt), .wrap_o(kx_wrap)
    );
    conv_axis_counter #(.MAX(K - 1), .WIDTH(KW)) u_ky (
        .clk(clk), .rst_n(rst_n), .en(fire && kx_wrap), .clr(clr),
        .cnt_o(ky_cnt), .wrap_o(ky_wrap)
    );
    conv_axis_counter #(.MAX(OFM_W - 1), .WIDTH(OWW)) u_ox (
        .clk(clk), .rst_n(rst_n), .en(fire && kx_wrap && ky_wrap), .clr(clr),
        .cnt_o(ox_cnt), .wrap_o(ox_wrap)
    );
    conv_axis_counter #(.MAX(OFM_H - 1), .WIDTH(OHW)) u_oy (
        .clk(clk), .rst_n(rst_n), .en(fire && kx_wrap && ky_wrap && ox_wrap), .clr(clr),
        .cnt_o(oy_cnt), .wrap_o(oy_wrap)
    );

    // Output-window coordinates only feed the wrap chain; keep them visible for debug.
    logic unused_win_pos;
    assign unused_win_pos = ^{ox_cnt, oy_cnt};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                        addr_d  = '0;
                    end else begin
                        // row_q tracks (oy*STRIDE+ky)*IFM_W, col_q tracks ox*STRIDE+kx
                        if (!kx_wrap) begin
                            col_d = col_q + ADDR_W'(1);
                        end else if (!ky_wrap) begin
                            col_d = col_q - COL_KBACK;
                            row_d = row_q + ROW_STEP;
                        end else if (!ox_wrap) begin
                            col_d = col_q + COL_OSTEP - COL_KBACK;
                            row_d = row_q - ROW_KBACK;
                        end else begin
                            col_d = '0;
                            row_d = row_q + ROW_OSTEP - ROW_KBACK;
                        end
                        addr_d = row_d + col_d;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign win_first_o  = valid_q && (kx_cnt == '0) && (ky_cnt == '0);
    assign win_last_o   = valid_q && kx_wrap && ky_wrap;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: two configurations (4x4/K3/S1 and 5x5/K3/S2)
// compared beat by beat against a nested-loop reference of the window walk.
module tb_conv_window_addr_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ready;
    int         sel;

    logic       a_busy, a_done, a_valid, a_first, a_last;
    logic [7:0] a_addr;
    logic       b_busy, b_done, b_valid, b_first, b_last;
    logic [7:0] b_addr;

    logic       o_busy, o_done, o_valid, o_first, o_last;
    logic [7:0] o_addr;

    int vectors     = 0;
    int miscompares = 0;

    int exp_addr[$];
    int exp_first[$];
    int exp_last[$];

    always #5 clk = ~clk;

    conv_window_addr_gen #(.IFM_W(4), .IFM_H(4), .K(3), .STRIDE(1), .ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start && (sel == 0)),
        .busy_o(a_busy), .done_o(a_done), .addr_o(a_addr), .addr_valid_o(a_valid),
        .addr_ready_i(ready), .win_first_o(a_first), .win_last_o(a_last)
    );

    conv_window_addr_gen #(.IFM_W(5), .IFM_H(5), .K(3), .STRIDE(2), .ADDR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start && (sel == 1)),
        .busy_o(b_busy), .done_o(b_done), .addr_o(b_addr), .addr_valid_o(b_valid),
        .addr_ready_i(ready), .win_first_o(b_first), .win_last_o(b_last)
    );

    always_comb begin
        o_busy  = (sel == 1) ? b_busy  : a_busy;
        o_done  = (sel == 1) ? b_done  : a_done;
        o_valid = (sel == 1) ? b_valid : a_valid;
        o_first = (sel == 1) ? b_first : a_first;
        o_last  = (sel == 1) ? b_last  : a_last;
        o_addr  = (sel == 1) ? b_addr  : a_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: enumerate windows in oy, ox, ky, kx order with plain arithmetic.
    task automatic build_model(input int w, input int h, input int k, input int s);
        int ow, oh;
        exp_addr.delete();
        exp_first.delete();
        exp_last.delete();
        ow = (w - k) / s + 1;
        oh = (h - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++) begin
                        exp_addr.push_back((oy * s + ky) * w + ox * s + kx);
                        exp_first.push_back((ky == 0 && kx == 0) ? 1 : 0);
                        exp_last.push_back((ky == k - 1 && kx == k - 1) ? 1 : 0);
                    end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_addr"},  32'(o_addr),  0);
        chk({tag, "_first"}, 32'(o_first), 0);
        chk({tag, "_last"},  32'(o_last),  0);
        chk({tag, "_busy"},  32'(o_busy),  0);
        chk({tag, "_done"},  32'(o_done),  0);
    endtask

    // Entered and left at a negedge; a following pass starts in the cycle after done.
    task automatic run_pass(input int s_sel, input int stall_at, input int glitch_at,
                            input int rst_at, input bit rand_rdy);
        int idx, cyc, stalled, n;
        bit glitched, aborted;
        sel = s_sel;
        if (s_sel == 1) build_model(5, 5, 3, 2);
        else            build_model(4, 4, 3, 1);
        n = exp_addr.size();
        #1;
        chk("idle_busy",  32'(o_busy),  0);
        chk("idle_valid", 32'(o_valid), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; stalled = 0; glitched = 0; aborted = 0;
        while (idx < n && cyc < 4000) begin
            chk("beat_valid", 32'(o_valid), 1);
            chk("beat_addr",  32'(o_addr),  32'(exp_addr[idx]));
            chk("beat_first", 32'(o_first), 32'(exp_first[idx]));
            chk("beat_last",  32'(o_last),  32'(exp_last[idx]));
            chk("beat_busy",  32'(o_busy),  1);
            chk("beat_done",  32'(o_done),  0);
            start = 1'b0;
            if (idx == glitch_at && !glitched) begin
                start = 1'b1;
                glitched = 1;
            end
            if (idx == rst_at) begin
                rst_n = 1'b0;
                start = 1'b1;
                ready = 1'b1;
                @(negedge clk);
                rst_n = 1'b0;
                rst_n = 1'b1;
                start = 1'b0;
                check_quiet("rst_mid");
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_no_done",  32'(o_done),  0);
                    chk("rst_no_valid", 32'(o_valid), 0);
                end
                aborted = 1;
                break;
            end
            if (idx == stall_at && stalled < 3) begin
                ready = 1'b0;
                stalled++;
            end else if (rand_rdy && $urandom_range(0, 3) == 0) begin
                ready = 1'b0;
            end else begin
                ready = 1'b1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        if (!aborted) begin
            chk("beat_count_reached", 32'(idx), 32'(n));
            chk("end_valid", 32'(o_valid), 0);
            chk("end_done",  32'(o_done),  1);
            chk("end_busy",  32'(o_busy),  1);
            @(negedge clk);
            chk("post_done",  32'(o_done),  0);
            chk("post_busy",  32'(o_busy),  0);
            chk("post_valid", 32'(o_valid), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        ready = 1'b1;
        sel   = 0;
        repeat (2) @(negedge clk);
        check_quiet("reset_a");
        sel = 1;
        #1;
        check_quiet("reset_b");
        rst_n = 1'b1;
        start = 1'b0;
        sel   = 0;
        @(negedge clk);

        run_pass(0, -1, -1, -1, 0);    // first window and full 4x4 pass
        run_pass(0, 4, -1, -1, 0);     // hold at address 5 for 3 cycles
        run_pass(0, -1, 7, -1, 0);     // start pulse during RUN
        run_pass(0, -1, -1, 20, 0);    // reset at beat 20
        run_pass(0, -1, -1, -1, 0);    // fresh pass after abort
        run_pass(1, -1, -1, -1, 0);    // stride 2 on 5x5
        for (int r = 0; r < 4; r++) begin
            run_pass(r % 2, -1, -1, -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_addr_gen.md
CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

Interface
REQ-001 SHALL have parameter IFM_W, default 14, meaning input feature-map width in pixels.
REQ-002 SHALL have parameter IFM_H, default 14, meaning input feature-map height in pixels.
REQ-003 SHALL have parameter K, default 3, meaning square kernel size.
REQ-004 SHALL have parameter STRIDE, default 1, meaning window step in x and y.
REQ-005 SHALL have parameter ADDR_W, default 8, meaning address width; must hold IFM_W*IFM_H-1.
REQ-006 SHALL have port clk, input, 1, meaning the clock; reset rst_n is synchronous, active-low.
REQ-007 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-008 SHALL have port start_i, input, 1, meaning a one-cycle request to begin one feature-map pass.
REQ-009 SHALL have port busy_o, output, 1, meaning a pass is in progress.
REQ-010 SHALL have port done_o, output, 1, meaning a one-cycle pulse at pass completion.
REQ-011 SHALL have port addr_o, output, ADDR_W, meaning the pixel read address.
REQ-012 SHALL have port addr_valid_o, output, 1, meaning addr_o is valid.
REQ-013 SHALL have port addr_ready_i, input, 1, meaning the consumer accepts addr_o.
REQ-014 SHALL have port win_first_o, output, 1, meaning the beat is kernel element (0,0) of a window.
REQ-015 SHALL have port win_last_o, output, 1, meaning the beat is kernel element (K-1,K-1) of a window.

Function
REQ-016 SHALL define OFM_W=(IFM_W-K)/STRIDE+1 and OFM_H=(IFM_H-K)/STRIDE+1, using integer floor division.
REQ-017 SHALL use FSM states IDLE, RUN and DONE: IDLE->RUN on start_i; RUN->DONE on the accepted final beat; DONE->IDLE unconditionally after 1 cycle.
REQ-018 SHALL ignore start_i outside IDLE.
REQ-019 SHALL use loop order, outermost first: oy, ox, ky, kx; each counter wraps to 0 at its maximum (OFM_H-1, OFM_W-1, K-1, K-1) and carries to the next outer counter.
REQ-020 SHALL compute addr_o=(oy*STRIDE+ky)*IFM_W+(ox*STRIDE+kx), registered so that it is aligned with addr_valid_o.
REQ-021 SHALL assert addr_valid_o in RUN, starting on the cycle after start_i is sampled, with no bubbles between beats while addr_ready_i=1.
REQ-022 SHALL advance the counters only on addr_valid_o && addr_ready_i; with addr_ready_i=0, addr_o, win_first_o and win_last_o hold stable.
REQ-023 SHALL drive win_first_o=(ky==0 && kx==0) and win_last_o=(ky==K-1 && kx==K-1), both qualified by addr_valid_o.
REQ-024 SHALL produce exactly OFM_H*OFM_W*K*K accepted beats per pass; the final beat has all counters at their maximum.
REQ-025 SHALL deassert addr_valid_o on the cycle after the final handshake, and assert done_o in that same cycle (the DONE state).
REQ-026 SHALL assert busy_o in RUN and DONE only.
REQ-027 SHALL allow start_i sampled in the cycle following done_o to begin a new pass from all-zero counters.

Reset
REQ-028 SHALL, while rst_n=0 at a clk edge, force state IDLE, all counters 0, addr_o=0, and addr_valid_o, win_first_o, win_last_o, busy_o, done_o all 0.
REQ-029 SHALL abort a pass on reset mid-RUN, without any done_o pulse, and ignore start_i in the reset cycle.

Structure
REQ-030 SHALL place the FSM state encoding and the OFM_W/OFM_H derivation in shared package conv_pkg.
REQ-031 SHALL implement each loop axis as an instance of sub-module conv_axis_counter, with parameters MAX and WIDTH, ports en, clr, cnt_o and wrap_o.
REQ-032 SHALL compute the address without a runtime multiplier: keep an incremental row base and column base in registers, and use constant multiplies only.

Verification
REQ-033 SHALL cover the first window: IFM 4x4, K=3, STRIDE=1, ready=1 -> addresses 0,1,2,4,5,6,8,9,10; win_first on 0; win_last on 10.
REQ-034 SHALL cover a full pass in the same configuration -> 36 beats; window starts at 0,1,4,5; last address 15; done_o high exactly 1 cycle after the 36th handshake.
REQ-035 SHALL cover stride: IFM 5x5, K=3, STRIDE=2 -> 36 beats; second window starts at 2; third window starts at 10; last address 24.
REQ-036 SHALL cover backpressure: addr_ready_i=0 for 3 cycles at beat 5 (address 5) -> addr_o holds 5; next accepted address is 6; total beat count unchanged.
REQ-037 SHALL cover reset mid-pass: rst_n=0 at beat 20 -> all outputs 0 next cycle, no done_o; a new start_i yields first address 0.
REQ-038 SHALL cover start ignored: start_i pulsed during RUN -> beat sequence and count unaffected.
